// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen
//
// Purpose: AXI-Stream packet generator. A one-cycle start latches a burst
// description (beats per packet, packets per burst, first data word) and
// the block then emits pkt_count packets of pkt_len beats. Each beat carries
// an incrementing data word that runs on across packet boundaries and wraps
// naturally at 2^DATA_WIDTH.
//
// Configuration macro: AXIS_PKT_GEN_GAP_EN
//   defined   -> gap_cycles port and GAP state exist. Packets are separated by
//                gap_cycles idle cycles, with tvalid low throughout the gap.
//   undefined -> packets are sent back-to-back.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   one-cycle burst request, accepted only in IDLE
//   pkt_len        in   beats per packet (sampled on accepted start)
//   pkt_count      in   packets per burst (sampled on accepted start)
//   seed           in   first tdata value (sampled on accepted start)
//   gap_cycles     in   idle cycles between packets (macro builds only)
//   m_axis_tvalid  out  stream valid
//   m_axis_tdata   out  stream data
//   m_axis_tlast   out  last beat of each packet
//   m_axis_tready  in   downstream ready
//   busy           out  burst in progress
//   done           out  one-cycle pulse at burst completion
//
// All outputs come straight from flops; tready only feeds next-state logic.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; a zero-length burst pulses done from here
// SEND  | tvalid high, presenting the current beat until it transfers
// GAP   | tvalid low, down-counting the inter-packet gap (macro builds)

module axis_pkt_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [LEN_WIDTH-1:0]  pkt_count,
    input  logic [DATA_WIDTH-1:0] seed,
`ifdef AXIS_PKT_GEN_GAP_EN
    input  logic [LEN_WIDTH-1:0]  gap_cycles,
`endif
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_TWO  = LEN_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

    state_t               state;
    // Down-counters: beats left in this packet (including the one on the
    // bus) and packets left in the burst (including the current one).
    // Terminal count is 1, so the full 2^LEN_WIDTH-1 range fits without
    // needing an extra bit.
    logic [LEN_WIDTH-1:0] beat_left;
    logic [LEN_WIDTH-1:0] pkt_left;
    logic [LEN_WIDTH-1:0] len_q;
`ifdef AXIS_PKT_GEN_GAP_EN
    logic [LEN_WIDTH-1:0] gap_q;
    logic [LEN_WIDTH-1:0] gap_left;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            beat_left     <= '0;
            pkt_left      <= '0;
            len_q         <= '0;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q         <= '0;
            gap_left      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (pkt_len == '0 || pkt_count == '0) begin
                            // Nothing to send: report completion without
                            // ever raising busy.
                            done <= 1'b1;
                        end else begin
                            len_q         <= pkt_len;
                            pkt_left      <= pkt_count;
                            beat_left     <= pkt_len;
`ifdef AXIS_PKT_GEN_GAP_EN
                            gap_q         <= gap_cycles;
`endif
                            m_axis_tdata  <= seed;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= (pkt_len == LEN_ONE);
                            busy          <= 1'b1;
                            state         <= SEND;
                        end
                    end
                end

                SEND: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= m_axis_tdata + DATA_ONE;
                        if (beat_left == LEN_ONE) begin
                            if (pkt_left == LEN_ONE) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                state         <= IDLE;
                            end else begin
                                pkt_left     <= pkt_left - LEN_ONE;
                                beat_left    <= len_q;
                                m_axis_tlast <= (len_q == LEN_ONE);
`ifdef AXIS_PKT_GEN_GAP_EN
                                if (gap_q != '0) begin
                                    m_axis_tvalid <= 1'b0;
                                    gap_left      <= gap_q;
                                    state         <= GAP;
                                end
`else
                                // Back-to-back: tvalid simply stays high.
                                state <= SEND;
`endif
                            end
                        end else begin
                            beat_left    <= beat_left - LEN_ONE;
                            m_axis_tlast <= (beat_left == LEN_TWO);
                        end
                    end
                end

`ifdef AXIS_PKT_GEN_GAP_EN
                GAP: begin
                    // tvalid is raised while leaving so that it is low for
                    // exactly gap_q cycles.
                    if (gap_left == LEN_ONE) begin
                        m_axis_tvalid <= 1'b1;
                        state         <= SEND;
                    end else begin
                        gap_left <= gap_left - LEN_ONE;
                    end
                end
`endif

                default: begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
module tb_axis_pkt_gen;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] pkt_len;
    logic [15:0] pkt_count;
    logic [31:0] seed;
`ifdef AXIS_PKT_GEN_GAP_EN
    logic [15:0] gap_cycles;
`endif
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    axis_pkt_gen #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .pkt_len       (pkt_len),
        .pkt_count     (pkt_count),
        .seed          (seed),
`ifdef AXIS_PKT_GEN_GAP_EN
        .gap_cycles    (gap_cycles),
`endif
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start request for one cycle; returns just after the accepting edge.
    task automatic do_start(input logic [31:0] s, input logic [15:0] len, input logic [15:0] cnt);
        seed      = s;
        pkt_len   = len;
        pkt_count = cnt;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] exp_d;
        logic rdy;

        reset_n       = 1'b0;
        start         = 1'b0;
        pkt_len       = '0;
        pkt_count     = '0;
        seed          = '0;
        m_axis_tready = 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
        gap_cycles    = '0;
`endif
        #12;
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata",  m_axis_tdata,           32'd0);
        check("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
        check("rst_busy",   {31'd0, busy},          32'd0);
        check("rst_done",   {31'd0, done},          32'd0);
        reset_n = 1'b1;
        tick();

        // Two packets of four beats from 0x10, tready held high.
        // A second start mid-burst must be ignored.
        m_axis_tready = 1'b1;
        do_start(32'h10, 16'd4, 16'd2);
        check("b1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("b1_valid", {31'd0, m_axis_tvalid}, 32'd1);
            check("b1_data",  m_axis_tdata, 32'h10 + i);
            check("b1_last",  {31'd0, m_axis_tlast}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
            check("b1_done",  {31'd0, done}, 32'd0);
            if (i == 2) begin
                seed      = 32'hAA;
                pkt_count = 16'd0;
                start     = 1'b1;
            end else begin
                start     = 1'b0;
            end
            tick();
        end
        check("b1_end_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("b1_end_busy",  {31'd0, busy},          32'd0);
        check("b1_end_done",  {31'd0, done},          32'd1);
        tick();
        check("b1_done_pulse", {31'd0, done}, 32'd0);

        // Three beats under a stalling tready: no drop, no duplicate, held data.
        m_axis_tready = 1'b0;
        do_start(32'h0, 16'd3, 16'd1);
        exp_d = 32'd0;
        cyc   = 0;
        while (exp_d < 32'd3 && cyc < 200) begin
            check("st_valid", {31'd0, m_axis_tvalid}, 32'd1);
            check("st_data",  m_axis_tdata, exp_d);
            check("st_last",  {31'd0, m_axis_tlast}, (exp_d == 32'd2) ? 32'd1 : 32'd0);
            rdy = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            m_axis_tready = rdy;
            tick();
            if (rdy) exp_d++;
            cyc++;
        end
        check("st_in_budget", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
        check("st_done",  {31'd0, done},          32'd1);
        check("st_valid0", {31'd0, m_axis_tvalid}, 32'd0);
        tick();

        // Data wraps through all-ones to zero.
        m_axis_tready = 1'b1;
        do_start(32'hFFFF_FFFE, 16'd4, 16'd1);
        check("wr_d0", m_axis_tdata, 32'hFFFF_FFFE);
        check("wr_l0", {31'd0, m_axis_tlast}, 32'd0);
        tick();
        check("wr_d1", m_axis_tdata, 32'hFFFF_FFFF);
        tick();
        check("wr_d2", m_axis_tdata, 32'h0000_0000);
        check("wr_l2", {31'd0, m_axis_tlast}, 32'd0);
        tick();
        check("wr_d3", m_axis_tdata, 32'h0000_0001);
        check("wr_l3", {31'd0, m_axis_tlast}, 32'd1);
        tick();
        check("wr_done", {31'd0, done}, 32'd1);
        tick();

        // Zero packet count and zero length: done only, never busy or valid.
        do_start(32'h55, 16'd5, 16'd0);
        check("z0_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("z0_busy",  {31'd0, busy},          32'd0);
        check("z0_done",  {31'd0, done},          32'd1);
        tick();
        check("z0_done_pulse", {31'd0, done}, 32'd0);
        do_start(32'h55, 16'd0, 16'd3);
        check("zl_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("zl_busy",  {31'd0, busy},          32'd0);
        check("zl_done",  {31'd0, done},          32'd1);
        tick();

        // Two packets of two beats: gap of three cycles, or back-to-back.
`ifdef AXIS_PKT_GEN_GAP_EN
        gap_cycles = 16'd3;
        do_start(32'h20, 16'd2, 16'd2);
        check("gp_d0", m_axis_tdata, 32'h20);
        tick();
        check("gp_d1", m_axis_tdata, 32'h21);
        check("gp_l1", {31'd0, m_axis_tlast}, 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("gp_gap_valid", {31'd0, m_axis_tvalid}, 32'd0);
            check("gp_gap_busy",  {31'd0, busy},          32'd1);
            tick();
        end
        check("gp_v2", {31'd0, m_axis_tvalid}, 32'd1);
        check("gp_d2", m_axis_tdata, 32'h22);
        tick();
        check("gp_d3", m_axis_tdata, 32'h23);
        check("gp_l3", {31'd0, m_axis_tlast}, 32'd1);
        tick();
        check("gp_done", {31'd0, done}, 32'd1);
        gap_cycles = 16'd0;
`else
        do_start(32'h20, 16'd2, 16'd2);
        for (int i = 0; i < 4; i++) begin
            check("bb_valid", {31'd0, m_axis_tvalid}, 32'd1);
            check("bb_data",  m_axis_tdata, 32'h20 + i);
            check("bb_last",  {31'd0, m_axis_tlast}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        check("bb_done", {31'd0, done}, 32'd1);
`endif
        tick();

        // Reset during beat 2 of 5, then a fresh burst from 0x100.
        do_start(32'h50, 16'd5, 16'd1);
        tick();
        tick();
        check("rs_pre_data", m_axis_tdata, 32'h52);
        reset_n = 1'b0;
        #1;
        check("rs_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rs_data",  m_axis_tdata,           32'd0);
        check("rs_last",  {31'd0, m_axis_tlast},  32'd0);
        check("rs_busy",  {31'd0, busy},          32'd0);
        check("rs_done",  {31'd0, done},          32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check("rs_idle_valid", {31'd0, m_axis_tvalid}, 32'd0);
        do_start(32'h100, 16'd2, 16'd1);
        check("rs_d0", m_axis_tdata, 32'h100);
        check("rs_l0", {31'd0, m_axis_tlast}, 32'd0);
        tick();
        check("rs_d1", m_axis_tdata, 32'h101);
        check("rs_l1", {31'd0, m_axis_tlast}, 32'd1);
        tick();
        check("rs_fin_done", {31'd0, done}, 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
